// File: rtl/bus_arbiter_rr.sv
// Two-master round-robin arbiter for the SoC simple bus.
// Holds one slave access outstanding at a time, returns the slave
// response to the owning master one cycle after completion, and ends
// a hung slave access with an error response after a fixed timeout.
module bus_arbiter_rr #(
  parameter int              ADDR_W         = 32,
  parameter int              DATA_W         = 32,
  parameter int              TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA    = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,
  output logic                s_req,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_be,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                owner
);

  localparam int BE_W = DATA_W / 8;
  localparam int TW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Last timer value before the access is declared hung
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state;
  state_t          state_nx;
  logic            grant0;
  logic            grant1;
  logic            last_grant;
  logic [TW-1:0]   timer;
  logic [DATA_W-1:0] rdata_q;
  logic            err_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; the round-robin pick favours whoever was not granted last
  always_comb begin
    state_nx = state;
    grant0   = 1'b0;
    grant1   = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req && (!m1_req || last_grant)) grant0 = 1'b1;
        else if (m1_req)                       grant1 = 1'b1;
        if (grant0 || grant1) state_nx = BUSY;
      end
      BUSY: begin
        // A late s_ready on the expiry cycle still counts as success
        if (s_ready || timer == TMAX) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: slave request during BUSY, one-cycle response pulse in RESP
  always_comb begin
    s_req    = (state == BUSY);
    m0_ready = (state == RESP) && !owner;
    m1_ready = (state == RESP) &&  owner;
    m0_rdata = m0_ready ? rdata_q : '0;
    m1_rdata = m1_ready ? rdata_q : '0;
    m0_err   = m0_ready ? err_q : 1'b0;
    m1_err   = m1_ready ? err_q : 1'b0;
  end

  // Latch the winner's request, run the timeout counter, capture the response
  always_ff @(posedge clk) begin
    if (rst) begin
      s_we       <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_be       <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      timer      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            s_we       <= grant1 ? m1_we    : m0_we;
            s_addr     <= grant1 ? m1_addr  : m0_addr;
            s_wdata    <= grant1 ? m1_wdata : m0_wdata;
            s_be       <= grant1 ? m1_be    : m0_be;
            owner      <= grant1;
            last_grant <= grant1;
            timer      <= '0;
          end
        end
        BUSY: begin
          if (s_ready) begin
            rdata_q <= s_rdata;
            err_q   <= 1'b0;
          end else if (timer == TMAX) begin
            rdata_q <= ERR_RDATA;
            err_q   <= 1'b1;
          end else begin
            // Saturating: never advances past TMAX
            timer <= timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  logic unused_be_w;
  assign unused_be_w = (BE_W == 0);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Randomised bench for bus_arbiter_rr. Expected behaviour comes from a
// transaction timeline: each grant schedules a slave window, a response
// cycle and the next free cycle, from which every output is predicted.
module tb_bus_arbiter_rr;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 16;
  localparam int NCYC = 3000;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_ready, m0_err;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [BW-1:0] m0_be;
  logic          m1_req, m1_we, m1_ready, m1_err;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [BW-1:0] m1_be;
  logic          s_req, s_we, s_ready, owner;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [BW-1:0] s_be;

  bus_arbiter_rr #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERRD)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_be(s_be), .s_ready(s_ready), .s_rdata(s_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Master-side pending requests
  logic        pend    [2];
  logic        we_r    [2];
  logic [31:0] addr_r  [2];
  logic [31:0] wdata_r [2];
  logic [3:0]  be_r    [2];

  // Current transaction timeline
  logic        t_valid;
  int          t_m, t_start, t_end, t_resp, t_d;
  logic        t_we, t_err;
  logic [31:0] t_addr, t_wdata, t_sd, t_exp;
  logic [3:0]  t_be;
  int          last_g;
  int          exp_owner;
  logic        rst_flag;

  task automatic new_req(input int i);
    pend[i]    = 1'b1;
    we_r[i]    = 1'($urandom_range(0, 1));
    addr_r[i]  = $urandom;
    wdata_r[i] = $urandom;
    be_r[i]    = 4'($urandom_range(0, 15));
  endtask

  initial begin
    logic in_win, is_resp, do_rst, free, owns;
    int   win, r, nrst;
    rst = 1'b1;
    {m0_req, m0_we, m0_addr, m0_wdata, m0_be} = '0;
    {m1_req, m1_we, m1_addr, m1_wdata, m1_be} = '0;
    s_ready = 1'b0;
    s_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; we_r[i] = 1'b0; addr_r[i] = '0; wdata_r[i] = '0; be_r[i] = '0;
    end
    t_valid = 1'b0; t_m = 0; t_start = 0; t_end = 0; t_resp = 0; t_d = 0;
    t_we = 1'b0; t_err = 1'b0; t_addr = '0; t_wdata = '0; t_sd = '0; t_exp = '0; t_be = '0;
    last_g = 1; exp_owner = 0; rst_flag = 1'b1; nrst = 0;

    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      cyc = k;
      // Compare this cycle's outputs with the timeline
      in_win  = t_valid && (k >= t_start) && (k <= t_end);
      is_resp = t_valid && (k == t_resp);
      chk("s_req", 32'(s_req), 32'(in_win));
      if (in_win) begin
        chk("s_we",    32'(s_we), 32'(t_we));
        chk("s_addr",  s_addr,    t_addr);
        chk("s_wdata", s_wdata,   t_wdata);
        chk("s_be",    32'(s_be), 32'(t_be));
      end
      if (rst_flag) begin
        chk("rst_s_we",    32'(s_we), 32'd0);
        chk("rst_s_addr",  s_addr,    32'd0);
        chk("rst_s_wdata", s_wdata,   32'd0);
        chk("rst_s_be",    32'(s_be), 32'd0);
      end
      chk("owner",    32'(owner),    32'(exp_owner));
      chk("m0_ready", 32'(m0_ready), 32'(is_resp && t_m == 0));
      chk("m0_rdata", m0_rdata,      (is_resp && t_m == 0) ? t_exp : 32'd0);
      chk("m0_err",   32'(m0_err),   32'(is_resp && t_m == 0 && t_err));
      chk("m1_ready", 32'(m1_ready), 32'(is_resp && t_m == 1));
      chk("m1_rdata", m1_rdata,      (is_resp && t_m == 1) ? t_exp : 32'd0);
      chk("m1_err",   32'(m1_err),   32'(is_resp && t_m == 1 && t_err));

      // Drive this cycle's inputs
      do_rst = (k < 2) || (k > 50 && in_win && nrst < 6 && $urandom_range(0, 99) < 3);
      if (do_rst && k >= 2) nrst++;
      rst      = do_rst;
      m0_req   = pend[0]; m0_we = we_r[0]; m0_addr = addr_r[0];
      m0_wdata = wdata_r[0]; m0_be = be_r[0];
      m1_req   = pend[1]; m1_we = we_r[1]; m1_addr = addr_r[1];
      m1_wdata = wdata_r[1]; m1_be = be_r[1];
      if (in_win && k == t_start + t_d) begin
        s_ready = 1'b1;
        s_rdata = t_sd;
      end else if (!in_win) begin
        s_ready = ($urandom_range(0, 99) < 15);
        s_rdata = $urandom;
      end else begin
        s_ready = 1'b0;
        s_rdata = $urandom;
      end

      // Arbitration decision for this cycle
      if (do_rst) begin
        t_valid = 1'b0; exp_owner = 0; last_g = 1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        rst_flag = 1'b1;
      end else begin
        rst_flag = 1'b0;
        free = !t_valid || (k > t_resp);
        if (free && (pend[0] || pend[1])) begin
          if (pend[0] && pend[1]) win = 1 - last_g;
          else                    win = pend[0] ? 0 : 1;
          t_valid = 1'b1; t_m = win;
          t_we = we_r[win]; t_addr = addr_r[win]; t_wdata = wdata_r[win]; t_be = be_r[win];
          t_start = k + 1;
          r = $urandom_range(0, 99);
          if (r < 60)      t_d = $urandom_range(0, 4);
          else if (r < 75) t_d = TO - 1;
          else if (r < 85) t_d = TO + 3;
          else             t_d = $urandom_range(5, TO - 2);
          t_err  = (t_d > TO - 1);
          t_end  = t_err ? t_start + TO - 1 : t_start + t_d;
          t_resp = t_end + 1;
          t_sd   = $urandom;
          t_exp  = t_err ? ERRD : t_sd;
          last_g = win;
          exp_owner = win;
        end
      end

      // Masters update their requests for the next cycle
      for (int i = 0; i < 2; i++) begin
        if (!do_rst && t_valid && k == t_resp && t_m == i) pend[i] = 1'b0;
        owns = t_valid && (t_m == i) && (k < t_resp);
        if (rst_flag) new_req(i);
        else if (!pend[i]) begin
          if ($urandom_range(0, 99) < 40) new_req(i);
        end else if (!owns && $urandom_range(0, 99) < 5) pend[i] = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Two-master, one-slave round-robin arbiter in front of the SoC simple bus.
- Master 0 is the CPU instruction-fetch port; master 1 is the CPU load/store port. The slave port feeds the bus decoder (RAM/UART).
- Serialises accesses with one transaction outstanding, registers the slave response back to the owning master, and terminates hung slave accesses with an error after a timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte enables = DATA_W/8)
TIMEOUT_CYCLES, 1024, max cycles s_req may stay unanswered before error termination (>=2)
ERR_RDATA, 32'hDEADBEEF, read data returned on timeout

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
m0_req  in  1  master 0 request, held until m0_ready
m0_we  in  1  master 0 write enable
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_be  in  DATA_W/8  master 0 byte enables
m0_ready  out  1  one-cycle completion pulse to master 0
m0_rdata  out  DATA_W  read data, valid with m0_ready
m0_err  out  1  timeout error, valid with m0_ready
m1_*  same set as m0_* for master 1
s_req  out  1  slave request
s_we  out  1  slave write enable
s_addr  out  ADDR_W  slave address
s_wdata  out  DATA_W  slave write data
s_be  out  DATA_W/8  slave byte enables
s_ready  in  1  slave completion pulse
s_rdata  in  DATA_W  slave read data, valid with s_ready
owner  out  1  current/last granted master index (debug)

Behaviour:
- Reset state: state=IDLE, all outputs 0, last_grant=1 so m0 wins the first tie.
- The reset values apply on the first clk edge with rst=1. Reset mid-transaction abandons it: no ready pulse, and s_req drops on the next edge.
- State IDLE:
  - No request: stay in IDLE, s_req=0.
  - Exactly one mN_req=1: grant N.
  - Both requesting: grant the master that is not last_grant.
  - On grant, at the same edge: latch we/addr/wdata/be of the winner into s_* registers, set s_req=1, owner=N, last_grant=N, clear timer, go to BUSY.
  - Latency: request visible in cycle C gives s_req=1 in cycle C+1.
- State BUSY:
  - s_* outputs are held constant.
  - s_ready=1: capture s_rdata, go to RESP, s_req=0 next cycle.
  - Otherwise the timer increments. When the timer reaches TIMEOUT_CYCLES-1 with no s_ready, go to RESP with err=1, rdata=ERR_RDATA, s_req=0.
  - s_ready arriving on the same cycle as expiry counts as success (err=0).
- State RESP, exactly one cycle:
  - Pulse m[owner]_ready=1 with registered rdata/err.
  - The other master's ready stays 0. rdata and err are 0 whenever ready=0.
  - Next state is IDLE unconditionally.
  - Requests seen during RESP are ignored. The owner's req is still high this cycle and must not be re-granted; the master updates req at this edge.
- Throughput: minimum 3 cycles per transaction (grant, slave cycle, response). Back-to-back contention alternates m0, m1, m0, ...
- A request dropped by a master before its grant is simply not served.
- Requests change only in IDLE-observed cycles; changes in BUSY are ignored because inputs are latched.
- s_ready while IDLE or RESP (spurious) is ignored.
- The timer is a clog2(TIMEOUT_CYCLES)-bit counter and saturates, never wraps.

Test Plan:
- Single master: m1 write addr=0x3F00 data=0x12345678 be=0xF, slave ready 2 cycles after s_req -> s_req rises 1 cycle after m1_req, s_* match inputs, m1_ready pulses once 1 cycle after s_ready, m0_ready stays 0.
- Contention from reset: m0 and m1 both request reads, slave returns 0xAAAA0000 then 0x0000BBBB -> m0 served first with 0xAAAA0000, then m1 with 0x0000BBBB; with both held continuously, grants alternate m0, m1, m0, m1.
- Timeout: TIMEOUT_CYCLES=16, m0 read, s_ready never asserted -> s_req high exactly 16 cycles, then m0_ready=1, m0_err=1, m0_rdata=0xDEADBEEF; a subsequent m1 read completes normally with err=0.
- Expiry race: s_ready asserted on the final timeout cycle with rdata=0x55 -> err=0, rdata=0x55.
- Reset mid-op: assert rst while in BUSY -> next cycle s_req=0 and both ready=0; after release the first tie is granted to m0.
- Held request: m0 keeps req high through the RESP cycle while m1 idle -> exactly one extra transaction is issued, starting in the IDLE cycle after RESP, with no duplicate grant during RESP.
